hssi_tc_mailbox_ctrl: RTL and testbench

- Host-side mailbox controller for the HSSI traffic controller (TG/TM/loopback CSRs).
- Decodes host 32-bit CSR accesses to the 4-word mailbox at TRAFFIC_CTRL_CMD_ADDR: CMD +0x0, ADDRESS +0x4, RDDATA +0x8, WRDATA +0xC.
- Sequences exactly one read or write per command onto the traffic controller's Avalon-MM CSR bus for the currently selected Ethernet port.
- Reports completion and timeout through CMD status bits.

---
 rtl/hssi_tc_mb_pkg.sv | 33 +++
 rtl/hssi_tc_mb_timeout.sv | 29 ++
 rtl/hssi_tc_mailbox_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hssi_tc_mailbox_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hssi_tc_mb_pkg.sv
// Shared mailbox definitions: word indices, command encodings, CMD status layout and FSM states.
// Imported by the mailbox controller and its timeout counter.
package hssi_tc_mb_pkg;

    localparam logic [1:0] MB_IDX_CMD     = 2'd0;
    localparam logic [1:0] MB_IDX_ADDRESS = 2'd1;
    localparam logic [1:0] MB_IDX_RDDATA  = 2'd2;
    localparam logic [1:0] MB_IDX_WRDATA  = 2'd3;

    localparam logic [1:0] MB_NOOP    = 2'b00;
    localparam logic [1:0] MB_RD      = 2'b01;
    localparam logic [1:0] MB_WR      = 2'b10;
    localparam logic [1:0] MB_ILLEGAL = 2'b11;

    typedef struct packed {
        logic [25:0] rsvd;
        logic        illegal_err;
        logic        timeout_err;
        logic        busy;
        logic        ack;
        logic        wr_pending;
        logic        rd_pending;
    } mb_cmd_status_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_DONE
    } mb_state_t;

endpackage

// File: rtl/hssi_tc_mb_timeout.sv
// Loadable down-counter guarding one target transaction; expired is combinational off the count.
// Loaded with TIMEOUT_CYC-1 at command accept, so expiry lands on the TIMEOUT_CYC-th active cycle.
module hssi_tc_mb_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/hssi_tc_mailbox_ctrl.sv
// Host CSR mailbox that issues one Avalon-MM read or write per command to the traffic controller.
// Host reads return after 1 cycle; target stalls via waitrequest, bounded by the timeout counter.
module hssi_tc_mailbox_ctrl
    import hssi_tc_mb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int NUM_PORTS   = 8,
    parameter int PORT_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_wr,
    input  logic              csr_rd,
    input  logic [1:0]        csr_addr,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    output logic              csr_rvalid,
    input  logic [PORT_W-1:0] port_sel,
    output logic [ADDR_W-1:0] tc_address,
    output logic [PORT_W-1:0] tc_port,
    output logic              tc_read,
    output logic              tc_write,
    output logic [31:0]       tc_writedata,
    input  logic              tc_waitrequest,
    input  logic [31:0]       tc_readdata,
    input  logic              tc_readdatavalid,
    output logic              busy
);
    if (PORT_W < $clog2(NUM_PORTS)) begin : g_port_w_check
        $error("PORT_W too narrow for NUM_PORTS");
    end

    mb_state_t      state, state_nxt;
    mb_cmd_status_t status;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]    wrdata_q, rddata_q, rd_mux;
    logic           rd_pending, wr_pending, ack, timeout_err, illegal_err;
    logic           idle, cmd_accept, timer_load, timer_en, timeout_hit, rd_capture;
    logic [1:0]     cmd;

    assign idle       = (state == ST_IDLE);
    assign busy       = !idle;
    assign cmd        = csr_wdata[1:0];
    assign cmd_accept = csr_wr && (csr_addr == MB_IDX_CMD) && idle;
    assign timer_load = cmd_accept && ((cmd == MB_RD) || (cmd == MB_WR));
    assign timer_en   = (state == ST_RD_REQ) || (state == ST_RD_WAIT) || (state == ST_WR_REQ);

    assign tc_address   = addr_q;
    assign tc_writedata = wrdata_q;

    hssi_tc_mb_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Timeout wins over a completion landing in the expiry cycle, so RDDATA stays untouched.
    always_comb begin
        state_nxt  = state;
        tc_read    = 1'b0;
        tc_write   = 1'b0;
        rd_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_accept && (cmd == MB_RD)) state_nxt = ST_RD_REQ;
                if (cmd_accept && (cmd == MB_WR)) state_nxt = ST_WR_REQ;
            end
            ST_RD_REQ: begin
                tc_read = 1'b1;
                if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end else if (!tc_waitrequest) begin
                    rd_capture = tc_readdatavalid;
                    state_nxt  = tc_readdatavalid ? ST_DONE : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end else if (tc_readdatavalid) begin
                    rd_capture = 1'b1;
                    state_nxt  = ST_DONE;
                end
            end
            ST_WR_REQ: begin
                tc_write = 1'b1;
                if (timeout_hit)         state_nxt = ST_IDLE;
                else if (!tc_waitrequest) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wrdata_q    <= '0;
            rddata_q    <= '0;
            tc_port     <= '0;
            rd_pending  <= 1'b0;
            wr_pending  <= 1'b0;
            ack         <= 1'b0;
            timeout_err <= 1'b0;
            illegal_err <= 1'b0;
        end else begin
            if (csr_wr && idle && (csr_addr == MB_IDX_ADDRESS)) addr_q   <= csr_wdata[ADDR_W-1:0];
            if (csr_wr && idle && (csr_addr == MB_IDX_WRDATA))  wrdata_q <= csr_wdata;
            if (cmd_accept) begin
                ack         <= 1'b0;
                timeout_err <= 1'b0;
                illegal_err <= 1'b0;
                case (cmd)
                    MB_RD: begin
                        rd_pending <= 1'b1;
                        tc_port    <= port_sel;
                    end
                    MB_WR: begin
                        wr_pending <= 1'b1;
                        tc_port    <= port_sel;
                    end
                    MB_ILLEGAL: begin
                        illegal_err <= 1'b1;
                        ack         <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rd_capture) rddata_q <= tc_readdata;
            if ((state == ST_DONE) || timeout_hit) begin
                ack        <= 1'b1;
                rd_pending <= 1'b0;
                wr_pending <= 1'b0;
            end
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

    always_comb begin
        status             = '0;
        status.rd_pending  = rd_pending;
        status.wr_pending  = wr_pending;
        status.ack         = ack;
        status.busy        = busy;
        status.timeout_err = timeout_err;
        status.illegal_err = illegal_err;
        case (csr_addr)
            MB_IDX_CMD:     rd_mux = status;
            MB_IDX_ADDRESS: rd_mux = 32'(addr_q);
            MB_IDX_RDDATA:  rd_mux = rddata_q;
            default:        rd_mux = wrdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rvalid <= 1'b0;
            csr_rdata  <= '0;
        end else begin
            csr_rvalid <= csr_rd;
            csr_rdata  <= csr_rd ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_hssi_tc_mailbox_ctrl.sv
// Scoreboarded bench: host read responses and target handshakes are checked by monitors
// against expectations queued by the directed stimulus.
module tb_hssi_tc_mailbox_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_wr, csr_rd;
    logic [1:0]  csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_rvalid;
    logic [3:0]  port_sel;
    logic [15:0] tc_address;
    logic [3:0]  tc_port;
    logic        tc_read, tc_write;
    logic [31:0] tc_writedata;
    logic        tc_waitrequest;
    logic [31:0] tc_readdata;
    logic        tc_readdatavalid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rd_hi  = 0;
    int wr_hi  = 0;

    logic [31:0] hq_exp[$];
    string       hq_name[$];
    bit          tq_wr[$];
    logic [31:0] tq_addr[$], tq_data[$], tq_port[$];

    hssi_tc_mailbox_ctrl #(
        .ADDR_W(16), .NUM_PORTS(8), .PORT_W(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
        .port_sel(port_sel),
        .tc_address(tc_address), .tc_port(tc_port), .tc_read(tc_read), .tc_write(tc_write),
        .tc_writedata(tc_writedata), .tc_waitrequest(tc_waitrequest),
        .tc_readdata(tc_readdata), .tc_readdatavalid(tc_readdatavalid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [31:0] d);
        csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
        @(posedge clk); #1;
        csr_wr = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        hq_exp.push_back(exp);
        hq_name.push_back(name);
        csr_rd = 1'b1; csr_addr = a;
        @(posedge clk); #1;
        csr_rd = 1'b0;
    endtask

    task automatic expect_tgt(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        tq_wr.push_back(w); tq_addr.push_back(a); tq_data.push_back(d); tq_port.push_back(p);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tc_read"},      32'(tc_read),    32'd0);
        chk({tag, "_tc_write"},     32'(tc_write),   32'd0);
        chk({tag, "_busy"},         32'(busy),       32'd0);
        chk({tag, "_tc_address"},   32'(tc_address), 32'd0);
        chk({tag, "_tc_port"},      32'(tc_port),    32'd0);
        chk({tag, "_tc_writedata"}, tc_writedata,    32'd0);
        chk({tag, "_csr_rvalid"},   32'(csr_rvalid), 32'd0);
        chk({tag, "_csr_rdata"},    csr_rdata,       32'd0);
    endtask

    // Host-read monitor
    always @(negedge clk) begin
        if (rst_n && csr_rvalid) begin
            if (hq_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid actual=0x%08h expected=none", csr_rdata);
            end else begin
                chk(hq_name.pop_front(), csr_rdata, hq_exp.pop_front());
            end
        end
    end

    // Target-bus monitor
    always @(negedge clk) begin
        if (rst_n) begin
            rd_hi += int'(tc_read);
            wr_hi += int'(tc_write);
            chk("req_exclusive", 32'(tc_read & tc_write), 32'd0);
            if ((tc_read || tc_write) && !tc_waitrequest) begin
                if (tq_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tgt_accept actual=rd%0d/wr%0d expected=none", tc_read, tc_write);
                end else begin
                    automatic bit          w = tq_wr.pop_front();
                    automatic logic [31:0] a = tq_addr.pop_front();
                    automatic logic [31:0] d = tq_data.pop_front();
                    automatic logic [31:0] p = tq_port.pop_front();
                    chk("tgt_is_write", 32'(tc_write), 32'(w));
                    chk("tgt_address", 32'(tc_address), a);
                    chk("tgt_port", 32'(tc_port), p);
                    if (w) chk("tgt_writedata", tc_writedata, d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        csr_wr = 1'b0; csr_rd = 1'b0; csr_addr = 2'd0; csr_wdata = '0;
        port_sel = '0; tc_waitrequest = 1'b0; tc_readdata = '0; tc_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        host_rd(2'd0, 32'h0, "reset_cmd");
        host_rd(2'd1, 32'h0, "reset_address");
        host_rd(2'd2, 32'h0, "reset_rddata");
        host_rd(2'd3, 32'h0, "reset_wrdata");

        // Write with 3 stall cycles
        port_sel = 4'd5;
        host_wr(2'd1, 32'h0000_0000);
        host_wr(2'd3, 32'h0000_0010);
        tc_waitrequest = 1'b1;
        expect_tgt(1'b1, 32'h0, 32'h10, 32'd5);
        wr_hi = 0; rd_hi = 0;
        host_wr(2'd0, 32'h2);
        host_rd(2'd0, 32'hA, "wr_busy_cmd");
        repeat (2) @(posedge clk);
        #1 tc_waitrequest = 1'b0;
        wait_idle(20);
        chk("wr_write_cycles", 32'(wr_hi), 32'd4);
        chk("wr_read_cycles", 32'(rd_hi), 32'd0);
        host_rd(2'd0, 32'h4, "wr_done_cmd");

        // Read, data 5 cycles after accept
        port_sel = 4'd3;
        host_wr(2'd1, 32'h0000_0101);
        expect_tgt(1'b0, 32'h101, 32'h0, 32'd3);
        host_wr(2'd0, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        tc_readdatavalid = 1'b1; tc_readdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        tc_readdatavalid = 1'b0; tc_readdata = '0;
        wait_idle(20);
        host_rd(2'd2, 32'hDEAD_BEEF, "rd_rddata");
        host_rd(2'd0, 32'h4, "rd_done_cmd");

        // Timeout with stuck waitrequest; busy-time writes must be dropped
        tc_waitrequest = 1'b1;
        rd_hi = 0; wr_hi = 0;
        host_wr(2'd0, 32'h1);
        host_rd(2'd0, 32'h9, "to_busy_cmd");
        host_wr(2'd0, 32'h2);
        host_wr(2'd1, 32'h0000_0055);
        wait_idle(40);
        chk("to_read_cycles", 32'(rd_hi), 32'd16);
        chk("to_write_cycles", 32'(wr_hi), 32'd0);
        tc_waitrequest = 1'b0;
        host_rd(2'd0, 32'h14, "to_cmd");
        host_rd(2'd1, 32'h101, "to_address_kept");
        host_rd(2'd2, 32'hDEAD_BEEF, "to_rddata_kept");
        tc_readdatavalid = 1'b1; tc_readdata = 32'h1234_5678;
        @(posedge clk); #1;
        tc_readdatavalid = 1'b0; tc_readdata = '0;
        host_rd(2'd2, 32'hDEAD_BEEF, "late_rdv_ignored");

        // Illegal command, then NOOP clears status
        rd_hi = 0; wr_hi = 0;
        host_wr(2'd0, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_access", 32'(rd_hi + wr_hi), 32'd0);
        host_rd(2'd0, 32'h24, "ill_cmd");
        host_wr(2'd0, 32'h0);
        host_rd(2'd0, 32'h0, "noop_clears");

        // Same-cycle accept and readdatavalid
        port_sel = 4'd2;
        rd_hi = 0;
        host_wr(2'd1, 32'h0000_0007);
        expect_tgt(1'b0, 32'h7, 32'h0, 32'd2);
        host_wr(2'd0, 32'h1);
        tc_readdatavalid = 1'b1; tc_readdata = 32'hCAFE_0001;
        host_rd(2'd0, 32'h9, "same_req_cmd");
        tc_readdatavalid = 1'b0; tc_readdata = '0;
        host_rd(2'd0, 32'h9, "same_done_cmd");
        host_rd(2'd0, 32'h4, "same_ack_cmd");
        host_rd(2'd2, 32'hCAFE_0001, "same_rddata");
        chk("same_read_cycles", 32'(rd_hi), 32'd1);

        // Reset during RD_WAIT, then a clean read
        port_sel = 4'd6;
        host_wr(2'd1, 32'h0000_0020);
        expect_tgt(1'b0, 32'h20, 32'h0, 32'd6);
        host_wr(2'd0, 32'h1);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        host_rd(2'd1, 32'h0, "post_rst_address");
        host_rd(2'd3, 32'h0, "post_rst_wrdata");
        host_rd(2'd0, 32'h0, "post_rst_cmd");
        port_sel = 4'd1;
        host_wr(2'd1, 32'h0000_0030);
        expect_tgt(1'b0, 32'h30, 32'h0, 32'd1);
        host_wr(2'd0, 32'h1);
        @(posedge clk); #1;
        tc_readdatavalid = 1'b1; tc_readdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        tc_readdatavalid = 1'b0; tc_readdata = '0;
        wait_idle(20);
        host_rd(2'd2, 32'hA5A5_5A5A, "post_rst_rddata");
        host_rd(2'd0, 32'h4, "post_rst_done_cmd");

        repeat (3) @(posedge clk);
        #1;
        chk("host_queue_drained", 32'(hq_exp.size()), 32'd0);
        chk("tgt_queue_drained", 32'(tq_wr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
